// File: rtl/async_queue_pkg.sv
// Shared definitions for the request/acknowledge queue: upstream FSM states
// and the log2 helper used to size pointers and the occupancy counter.
package async_queue_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/async_queue_mem.sv
// Queue storage: depth x data_width registers with one synchronous write
// port and one combinational read port.
module queue_mem
  import async_queue_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  // Contents are never cleared; the pointers decide what is valid.
  logic [data_width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/async_queue.sv
// Request/acknowledge queue: a two-state upstream FSM accepts words into
// FIFO storage, and the downstream side pops at most one word every two cycles.
module async_queue
  import async_queue_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   req_l,
  input  logic                   ack_l,
  input  logic [data_width-1:0]  din,
  input  logic [output_size-1:0] req_r,
  output logic                   ack_r,
  output logic [data_width-1:0]  dout,
  output logic [clog2(depth):0]  count
);

  localparam int addr_width  = clog2(depth);
  localparam int count_width = addr_width + 1;
  localparam logic [count_width-1:0] full_count = count_width'(depth);

  state_t                  state_q,  state_d;
  logic                    req_l_q,  req_l_d;
  logic                    ack_r_q,  ack_r_d;
  logic [data_width-1:0]   dout_q,   dout_d;
  logic [count_width-1:0]  count_q,  count_d;
  logic [addr_width-1:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0]   rd_ptr_q, rd_ptr_d;
  logic                    push;
  logic                    pop;
  logic [data_width-1:0]   rd_data;

  queue_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Pop looks at the pre-edge count, so a word written this edge cannot be popped.
  always_comb begin
    push     = (state_q == REQ) && ack_l;
    pop      = (count_q != '0) && (&req_r) && !ack_r_q;
    wr_ptr_d = wr_ptr_q + addr_width'(push);
    rd_ptr_d = rd_ptr_q + addr_width'(pop);
    count_d  = count_q + count_width'(push) - count_width'(pop);
    ack_r_d  = pop;
    dout_d   = pop ? rd_data : dout_q;

    state_d = state_q;
    case (state_q)
      IDLE: if (count_q < full_count) state_d = REQ;
      REQ:  if (push && (count_d >= full_count)) state_d = IDLE;
    endcase
    req_l_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_l_q  <= 1'b0;
      ack_r_q  <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_l_q  <= req_l_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = dout_q;
  assign count = count_q;

endmodule
